control_sequencer: RTL and testbench

//   Hardwired multi-cycle control unit for the Phase-1 datapath. It sits directly upstream of the datapath
//   and replaces the hand-coded state sequences the benches use to drive it.
//   - Runs fetch (T0-T2).
//   - Decodes IR and runs execute (T3-T6) for ALU register-format, mul/div and neg/not instructions.
//   - Drives every datapath strobe, including register-file Rin/Rout selects decoded from the IR fields.

---
 rtl/cpu_pkg.sv | 37 +++
 rtl/reg_select_decode.sv | 13 +
 rtl/control_sequencer.sv | 152 +++++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared opcodes, IR field positions, sequencer states and instruction classes
// for the Phase-1 control sequencer.
package cpu_pkg;

  localparam int OP_LSB = 27;
  localparam int RA_LSB = 23;
  localparam int RB_LSB = 19;
  localparam int RC_LSB = 15;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_AND  = 5'h02;
  localparam logic [4:0] OP_OR   = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_SHRA = 5'h05;
  localparam logic [4:0] OP_SHL  = 5'h06;
  localparam logic [4:0] OP_ROR  = 5'h07;
  localparam logic [4:0] OP_ROL  = 5'h08;
  localparam logic [4:0] OP_MUL  = 5'h0F;
  localparam logic [4:0] OP_DIV  = 5'h10;
  localparam logic [4:0] OP_NEG  = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
  } state_t;

  typedef enum logic [1:0] {C_ALU, C_MULDIV, C_UNARY, C_ILL} iclass_t;

  function automatic iclass_t op_class(input logic [4:0] op);
    if (op <= OP_ROL)                  return C_ALU;
    if (op == OP_MUL || op == OP_DIV)  return C_MULDIV;
    if (op == OP_NEG || op == OP_NOT)  return C_UNARY;
    return C_ILL;
  endfunction

endpackage

// File: rtl/reg_select_decode.sv
// One-hot register select decoder with enable; output is all-zero when disabled.
module reg_select_decode #(
  parameter int REGW  = 4,
  parameter int NREGS = 16
) (
  input  logic [REGW-1:0]  sel,
  input  logic             en,
  output logic [NREGS-1:0] onehot
);

  assign onehot = en ? (NREGS'(1) << sel) : '0;

endmodule

// File: rtl/control_sequencer.sv
// Hardwired multi-cycle control unit: fetch T0-T2, decode and execute T3-T6.
// Strobes are a combinational decode of the state register and the IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int OPW   = 5,
  parameter int REGW  = 4,
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      ir,
  output logic [NREGS-1:0] reg_in,
  output logic [NREGS-1:0] reg_out,
  output logic             pc_out,
  output logic             pc_in,
  output logic             inc_pc,
  output logic             mar_in,
  output logic             read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             z_in,
  output logic             zlow_out,
  output logic             zhigh_out,
  output logic             lo_in,
  output logic             hi_in,
  output logic [OPW-1:0]   alu_control,
  output logic             busy,
  output logic             instr_done,
  output logic             illegal
);

  state_t          state;
  logic [OPW-1:0]  opcode;
  iclass_t         cls;
  logic            is_last;
  logic            ra_in_en, ra_out_en, rb_out_en, rc_out_en;

  logic [2:0][REGW-1:0]  fld;
  logic [2:0]            dec_en;
  logic [2:0][NREGS-1:0] dec_oh;
  logic                  unused_ir;

  assign opcode    = ir[OP_LSB +: OPW];
  assign cls       = op_class(opcode);
  assign unused_ir = ^ir[RC_LSB-1:0];

  assign is_last = (state == S_T4 && cls == C_UNARY) ||
                   (state == S_T5 && cls == C_ALU)   ||
                   (state == S_T6);

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      illegal <= 1'b0;
    end else if (is_last) begin
      state <= run ? S_T0 : S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (run) state <= S_T0;
        S_T0:   state <= S_T1;
        S_T1:   state <= S_T2;
        S_T2:   state <= S_T3;
        S_T3: begin
          if (cls == C_ILL) begin
            state   <= S_HALT;
            illegal <= 1'b1;
          end else begin
            state <= S_T4;
          end
        end
        S_T4:   state <= S_T5;
        S_T5:   state <= S_T6;
        S_HALT: state <= S_HALT;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    read = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; zhigh_out = 1'b0;
    lo_in = 1'b0; hi_in = 1'b0; instr_done = 1'b0;
    alu_control = '0;
    ra_in_en = 1'b0; ra_out_en = 1'b0; rb_out_en = 1'b0; rc_out_en = 1'b0;
    case (state)
      S_T0: begin
        pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1;
        alu_control = OP_ADD;
      end
      S_T1: begin
        zlow_out = 1'b1; pc_in = 1'b1; read = 1'b1; mdr_in = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1; ir_in = 1'b1;
      end
      S_T3: begin
        case (cls)
          C_ALU:    begin rb_out_en = 1'b1; y_in = 1'b1; end
          C_MULDIV: begin ra_out_en = 1'b1; y_in = 1'b1; end
          C_UNARY:  begin rb_out_en = 1'b1; alu_control = opcode; z_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T4: begin
        case (cls)
          C_ALU:    begin rc_out_en = 1'b1; alu_control = opcode; z_in = 1'b1; end
          C_MULDIV: begin rb_out_en = 1'b1; alu_control = opcode; z_in = 1'b1; end
          C_UNARY:  begin zlow_out = 1'b1; ra_in_en = 1'b1; instr_done = 1'b1; end
          default:  ;
        endcase
      end
      S_T5: begin
        case (cls)
          C_ALU:    begin zlow_out = 1'b1; ra_in_en = 1'b1; instr_done = 1'b1; end
          C_MULDIV: begin zlow_out = 1'b1; lo_in = 1'b1; end
          default:  ;
        endcase
      end
      S_T6: begin
        zhigh_out = 1'b1; hi_in = 1'b1; instr_done = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE) && (state != S_HALT);

  // Ra serves as a read port (mul/div) and the write port, never in the same state.
  assign fld[0]    = ir[RA_LSB +: REGW];
  assign fld[1]    = ir[RB_LSB +: REGW];
  assign fld[2]    = ir[RC_LSB +: REGW];
  assign dec_en[0] = ra_in_en | ra_out_en;
  assign dec_en[1] = rb_out_en;
  assign dec_en[2] = rc_out_en;

  for (genvar g = 0; g < 3; g++) begin : g_dec
    reg_select_decode #(.REGW(REGW), .NREGS(NREGS)) u_dec (
      .sel    (fld[g]),
      .en     (dec_en[g]),
      .onehot (dec_oh[g])
    );
  end

  assign reg_in  = ra_in_en ? dec_oh[0] : '0;
  assign reg_out = (ra_out_en ? dec_oh[0] : '0) | dec_oh[1] | dec_oh[2];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed vector table, hand-written corner sequences and a randomized
// instruction stream checked against a step-list model of the sequencer.
module tb_control_sequencer;

  typedef struct packed {
    logic [15:0] reg_in;
    logic [15:0] reg_out;
    logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
    logic [4:0] alu;
    logic busy, done, illegal;
  } out_t;

  typedef struct {
    string       nm;
    logic [31:0] ir;
    logic        run;
    out_t        exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        run   = 1'b0;
  logic [31:0] ir    = '0;
  logic [15:0] reg_in, reg_out;
  logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in;
  logic [4:0] alu_control;
  logic busy, instr_done, illegal;

  int checks = 0;
  int failures = 0;
  out_t act;
  vec_t tbl[$];
  out_t exp_q[$];

  control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .ir(ir),
    .reg_in(reg_in), .reg_out(reg_out),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .zlow_out(zlow_out), .zhigh_out(zhigh_out),
    .lo_in(lo_in), .hi_in(hi_in), .alu_control(alu_control),
    .busy(busy), .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign act = {reg_in, reg_out, pc_out, pc_in, inc_pc, mar_in, read, mdr_in,
                mdr_out, ir_in, y_in, z_in, zlow_out, zhigh_out, lo_in, hi_in,
                alu_control, busy, instr_done, illegal};

  task automatic chk(input string nm, input out_t e);
    int drivers;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, e);
    end
    drivers = int'(act.pc_out) + int'(act.mdr_out) + int'(act.zlow_out) +
              int'(act.zhigh_out) + $countones(act.reg_out);
    checks++;
    if (drivers > 1) begin
      failures++;
      $display("FAIL %s bus_drivers got=%0d exp<=1", nm, drivers);
    end
  endtask

  function automatic out_t fetch(input int t);
    out_t e = '0;
    e.busy = 1'b1;
    case (t)
      0: begin e.pc_out = 1; e.mar_in = 1; e.inc_pc = 1; e.z_in = 1; end
      1: begin e.zlow_out = 1; e.pc_in = 1; e.read = 1; e.mdr_in = 1; end
      default: begin e.mdr_out = 1; e.ir_in = 1; end
    endcase
    return e;
  endfunction

  task automatic add(input string nm, input logic [31:0] i, input logic r, input out_t e);
    vec_t v;
    v.nm = nm; v.ir = i; v.run = r; v.exp = e;
    tbl.push_back(v);
  endtask

  // Expected per-cycle outputs of one instruction, T0 through its final step.
  task automatic model(input logic [31:0] i);
    out_t b, e;
    int op;
    logic [15:0] ra, rb, rc;
    op = int'(i >> 27);
    ra = 16'(1) << ((i >> 23) & 15);
    rb = 16'(1) << ((i >> 19) & 15);
    rc = 16'(1) << ((i >> 15) & 15);
    b = '0; b.busy = 1'b1;
    exp_q.delete();
    for (int t = 0; t < 3; t++) exp_q.push_back(fetch(t));
    if (op <= 8) begin
      e = b; e.reg_out = rb; e.y_in = 1; exp_q.push_back(e);
      e = b; e.reg_out = rc; e.alu = 5'(op); e.z_in = 1; exp_q.push_back(e);
      e = b; e.zlow_out = 1; e.reg_in = ra; e.done = 1; exp_q.push_back(e);
    end else if (op == 15 || op == 16) begin
      e = b; e.reg_out = ra; e.y_in = 1; exp_q.push_back(e);
      e = b; e.reg_out = rb; e.alu = 5'(op); e.z_in = 1; exp_q.push_back(e);
      e = b; e.zlow_out = 1; e.lo_in = 1; exp_q.push_back(e);
      e = b; e.zhigh_out = 1; e.hi_in = 1; e.done = 1; exp_q.push_back(e);
    end else begin
      e = b; e.reg_out = rb; e.alu = 5'(op); e.z_in = 1; exp_q.push_back(e);
      e = b; e.zlow_out = 1; e.reg_in = ra; e.done = 1; exp_q.push_back(e);
    end
  endtask

  initial begin
    out_t z, e;
    logic [4:0] legal_ops [13];
    logic in_t0;
    z = '0;
    legal_ops = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                  5'h08, 5'h0F, 5'h10, 5'h11, 5'h12};

    // reset state
    repeat (2) begin @(negedge clock); chk("reset", z); end
    clear = 1'b1;
    @(posedge clock); #1;

    // directed table: two back-to-back rols, then mul chained into not
    add("rol_idle", 32'h43820000, 1'b1, z);
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 3; t++) add("rol_fetch", 32'h43820000, 1'b1, fetch(t));
      e = '0; e.busy = 1; e.reg_out = 16'h0001; e.y_in = 1; add("rol_t3", 32'h43820000, 1'b1, e);
      e = '0; e.busy = 1; e.reg_out = 16'h0010; e.alu = 5'h08; e.z_in = 1; add("rol_t4", 32'h43820000, 1'b0, e);
      e = '0; e.busy = 1; e.zlow_out = 1; e.reg_in = 16'h0080; e.done = 1;
      add("rol_t5", 32'h43820000, (k == 0), e);
    end
    add("rol_back_idle", 32'h79880000, 1'b1, z);
    for (int t = 0; t < 3; t++) add("mul_fetch", 32'h79880000, 1'b1, fetch(t));
    e = '0; e.busy = 1; e.reg_out = 16'h0008; e.y_in = 1; add("mul_t3", 32'h79880000, 1'b1, e);
    e = '0; e.busy = 1; e.reg_out = 16'h0002; e.alu = 5'h0F; e.z_in = 1; add("mul_t4", 32'h79880000, 1'b0, e);
    e = '0; e.busy = 1; e.zlow_out = 1; e.lo_in = 1; add("mul_t5", 32'h79880000, 1'b0, e);
    e = '0; e.busy = 1; e.zhigh_out = 1; e.hi_in = 1; e.done = 1; add("mul_t6", 32'h79880000, 1'b1, e);
    for (int t = 0; t < 3; t++) add("not_fetch", 32'h91280000, 1'b1, fetch(t));
    e = '0; e.busy = 1; e.reg_out = 16'h0020; e.alu = 5'h12; e.z_in = 1; add("not_t3", 32'h91280000, 1'b1, e);
    e = '0; e.busy = 1; e.zlow_out = 1; e.reg_in = 16'h0004; e.done = 1; add("not_t4", 32'h91280000, 1'b0, e);
    add("not_idle", 32'h91280000, 1'b0, z);

    foreach (tbl[i]) begin
      ir = tbl[i].ir; run = tbl[i].run;
      @(negedge clock); chk(tbl[i].nm, tbl[i].exp);
      @(posedge clock); #1;
    end

    // randomized instruction stream; run toggles freely mid-instruction
    in_t0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ri;
      logic ra_after;
      ri = {legal_ops[$urandom_range(0, 12)], 27'($urandom)};
      ra_after = (n == 39) ? 1'b0 : 1'($urandom_range(0, 1));
      model(ri);
      ir = ri;
      if (!in_t0) begin
        run = 1'b1;
        @(negedge clock); chk("rand_idle", z);
        @(posedge clock); #1;
      end
      foreach (exp_q[i]) begin
        run = (i == exp_q.size() - 1) ? ra_after : 1'($urandom_range(0, 1));
        @(negedge clock); chk("rand_step", exp_q[i]);
        @(posedge clock); #1;
      end
      in_t0 = ra_after;
    end
    run = 1'b0;
    @(negedge clock); chk("rand_end_idle", z);

    // asynchronous reset in the middle of a rol's T4
    @(posedge clock); #1;
    ir = 32'h43820000; run = 1'b1;
    repeat (5) @(posedge clock);
    #1 run = 1'b0;
    @(negedge clock);
    e = '0; e.busy = 1; e.reg_out = 16'h0010; e.alu = 5'h08; e.z_in = 1;
    chk("rst_pre_t4", e);
    #1 clear = 1'b0;
    #1 chk("rst_async", z);
    @(posedge clock); #1 chk("rst_held", z);
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1 chk("rst_released", z);

    // undefined opcode: fetch, dead T3, then absorbing HALT with sticky illegal
    ir = 32'hF8000000; run = 1'b1;
    @(posedge clock); #1;
    for (int t = 0; t < 3; t++) begin
      @(negedge clock); chk("ill_fetch", fetch(t));
      @(posedge clock); #1;
    end
    @(negedge clock);
    e = '0; e.busy = 1; chk("ill_t3", e);
    @(posedge clock); #1;
    e = '0; e.illegal = 1;
    repeat (4) begin
      @(negedge clock); chk("ill_halt", e);
      @(posedge clock); #1;
    end
    ir = 32'h43820000;
    @(negedge clock); chk("ill_halt_legal_ir", e);
    clear = 1'b0; run = 1'b0;
    #1 chk("ill_cleared", z);
    @(negedge clock) clear = 1'b1;
    @(posedge clock); #1;
    @(negedge clock); chk("ill_idle_after", z);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
